poly_sum_combine: RTL and testbench
===================================

// Module: poly_sum_combine
// PURPOSE
//  Downstream stage of the LAC polynomial multiplier; consumes its o_sum_one / o_sum_mone result vectors.
//  Computes c[k] = (sum_one[k] - sum_mone[k]) mod Q for all N coefficients.
//  Streams c out LANES coefficients per beat over a valid/ready handshake to the encode/compress stage.
//  Ends each polynomial with a one-cycle done pulse.
// PARAMETERS
//  WIDTH  8    coefficient width in bits
//  N      512  coefficients per polynomial
//  Q      251  modulus
//  LANES  4    coefficients per output beat; N % LANES == 0
// PORTS
//  i_clock     in   1             clock; all state on rising edge
//  i_reset     in   1             reset, asynchronous, active-low
//  i_start     in   1             1-cycle pulse: multiplier results valid (driven from multiplier o_done)
//  i_sum_one   in   WIDTH*N       coeff k at bits [WIDTH*k +: WIDTH]
//  i_sum_mone  in   WIDTH*N       same packing as i_sum_one
//  i_ready     in   1             downstream accepts beat when o_valid && i_ready
//  o_coeff     out  WIDTH*LANES   lane j = coeff beat*LANES+j, at bits [WIDTH*j +: WIDTH]
//  o_valid     out  1             o_coeff holds a valid beat
//  o_last      out  1             current beat is beat N/LANES-1
//  o_busy      out  1             high in RUN
//  o_done      out  1             1-cycle pulse after last beat accepted
// BEHAVIOUR
//  - Reset (i_reset=0, async): state=IDLE, beat=0; o_coeff=0, o_valid=0, o_last=0, o_busy=0, o_done=0.
//    Reset mid-stream aborts the polynomial; no done pulse is issued.
//  - Inputs are not captured. Upstream holds i_sum_one/i_sum_mone stable from i_start until o_done.
//  - FSM states IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: i_start=1 -> RUN. On the same edge, beat 0 is loaded into o_coeff, o_valid=1, o_busy=1.
//    Latency: first beat is valid 1 cycle after i_start.
//  - RUN, o_valid && i_ready:
//    - beat < N/LANES-1: beat+1 is loaded on that edge; o_valid stays 1. One beat per cycle at full throughput.
//    - beat == N/LANES-1: -> DONE; o_valid=0, o_last=0, o_busy=0.
//  - RUN, i_ready=0: o_coeff, o_last and beat hold unchanged. No beat is lost or duplicated.
//  - DONE: o_done=1 for exactly one cycle, then -> IDLE.
//  - i_start is ignored in RUN and DONE.
//  - o_last is registered alongside o_coeff: high exactly while the last beat is presented.
//  - Arithmetic per lane, combinational before the o_coeff register:
//    - t = a + Q - b, WIDTH+2 bits unsigned
//    - c = (t >= Q) ? t - Q : t
//    - Exact for a, b < Q. Inputs >= Q are outside contract; the formula above still defines the output.
//  - Beat counter is clog2(N/LANES) bits. It does not wrap within a polynomial and is cleared on entry to RUN.
// TESTING
//  1. Reset with i_reset=0 and i_ready=1 -> all outputs 0. i_start pulsed during reset -> no beats.
//  2. sum_one[k]=k%251, sum_mone=0, i_ready=1.
//     -> 128 beats on consecutive cycles starting 1 cycle after i_start; beat0 lanes = {3,2,1,0}.
//     -> o_last on beat 127 only; o_done pulses 1 cycle after beat 127.
//  3. Wrap: sum_one=0, sum_mone=1 -> every coeff 250. sum_one=250, sum_mone=250 -> 0. sum_one=5, sum_mone=250 -> 6.
//  4. Random a, b < 251 with random i_ready (~50%) -> scoreboard matches (a-b) mod 251 in order;
//     o_coeff stable during every stall.
//  5. i_start re-pulsed at beat 40 -> ignored; still exactly 128 beats and one o_done.
//  6. i_reset asserted at beat 60 -> o_valid=0 immediately (async), no o_done.
//     A new i_start then restarts from beat 0.

Source files
------------

// File: rtl/poly_sum_combine_if.sv
// Bus between the polynomial multiplier, poly_sum_combine and the encode stage.
interface poly_sum_combine_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 512,
    parameter int unsigned LANES = 4
);
    logic                     i_start;
    logic [WIDTH*N-1:0]       i_sum_one;
    logic [WIDTH*N-1:0]       i_sum_mone;
    logic                     i_ready;
    logic [WIDTH*LANES-1:0]   o_coeff;
    logic                     o_valid;
    logic                     o_last;
    logic                     o_busy;
    logic                     o_done;

    // Environment side: drives start/data/ready, observes the output stream
    modport master (
        output i_start, i_sum_one, i_sum_mone, i_ready,
        input  o_coeff, o_valid, o_last, o_busy, o_done
    );

    // Combiner side
    modport slave (
        input  i_start, i_sum_one, i_sum_mone, i_ready,
        output o_coeff, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/poly_sum_combine.sv
// Combines multiplier partial sums c[k] = (sum_one[k] - sum_mone[k]) mod Q and
// streams the result LANES coefficients per beat over valid/ready.
module poly_sum_combine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 512,
    parameter int unsigned Q     = 251,
    parameter int unsigned LANES = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    poly_sum_combine_if.slave bus
);

    localparam int unsigned BEATS = N / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned TW    = WIDTH + 2;
    localparam int unsigned OW    = WIDTH * LANES;

    localparam logic [TW-1:0] Q_T       = TW'(Q);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q,  beat_d;
    logic [OW-1:0] coeff_q, coeff_d;
    logic          valid_q, valid_d;
    logic          last_q,  last_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [BW-1:0] load_idx_c;
    logic [OW-1:0] lanes_c;

    // Per-lane modular subtraction for the beat selected by load_idx_c
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int unsigned J = j;
        logic [WIDTH-1:0] a_c;
        logic [WIDTH-1:0] b_c;
        logic [TW-1:0]    t_c;

        assign a_c = bus.i_sum_one [WIDTH * (32'(load_idx_c) * LANES + J) +: WIDTH];
        assign b_c = bus.i_sum_mone[WIDTH * (32'(load_idx_c) * LANES + J) +: WIDTH];
        assign t_c = TW'(a_c) + Q_T - TW'(b_c);
        assign lanes_c[WIDTH*J +: WIDTH] = (t_c >= Q_T) ? WIDTH'(t_c - Q_T) : WIDTH'(t_c);
    end

    // Next-state, beat sequencing and output register loads
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        coeff_d    = coeff_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_idx_c = beat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d    = S_RUN;
                    beat_d     = '0;
                    load_idx_c = '0;
                    coeff_d    = lanes_c;
                    valid_d    = 1'b1;
                    last_d     = (BEATS == 1);
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                if (valid_q && bus.i_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d     = beat_q + BW'(1);
                        load_idx_c = beat_q + BW'(1);
                        coeff_d    = lanes_c;
                        last_d     = ((beat_q + BW'(1)) == LAST_BEAT);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any polynomial in flight
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            coeff_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            coeff_q <= coeff_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_coeff = coeff_q;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;

endmodule

// File: tb/tb_poly_sum_combine.sv
// Bench for poly_sum_combine: directed and random polynomials against a modular-arithmetic model.
module tb_poly_sum_combine;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 512;
    localparam int unsigned Q     = 251;
    localparam int unsigned LANES = 4;
    localparam int          BEATS = N / LANES;
    localparam int          QI    = 251;
    localparam int          MAX_CYC = 4000;

    logic clk = 1'b0;
    logic rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    int so[N];
    int sm[N];

    poly_sum_combine_if #(.WIDTH(WIDTH), .N(N), .LANES(LANES)) bus ();

    poly_sum_combine #(.WIDTH(WIDTH), .N(N), .Q(Q), .LANES(LANES)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // (a - b) mod Q for operands already reduced mod Q
    function automatic int ref_c(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) d = d + QI;
        return d;
    endfunction

    function automatic logic [WIDTH*LANES-1:0] exp_beat(input int b);
        logic [WIDTH*LANES-1:0] r;
        r = '0;
        for (int j = 0; j < LANES; j++)
            r[WIDTH*j +: WIDTH] = WIDTH'(ref_c(so[b*LANES+j], sm[b*LANES+j]));
        return r;
    endfunction

    task automatic load_vec();
        for (int k = 0; k < N; k++) begin
            bus.i_sum_one [WIDTH*k +: WIDTH] = WIDTH'(so[k]);
            bus.i_sum_mone[WIDTH*k +: WIDTH] = WIDTH'(sm[k]);
        end
    endtask

    // One polynomial: start, consume beats, optionally re-pulse start or reset mid-stream
    task automatic run_poly(input bit rand_ready, input int restart_at, input int reset_at);
        int beat;
        int cyc;
        bit rdy;
        beat = 0;
        cyc  = 0;
        load_vec();
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        chk("first_valid", bus.o_valid, 1);
        chk("first_busy", bus.o_busy, 1);
        while (beat < BEATS && cyc < MAX_CYC) begin
            chk("valid", bus.o_valid, 1);
            chk("coeff", bus.o_coeff, exp_beat(beat));
            chk("last", bus.o_last, beat == BEATS - 1);
            chk("done_low", bus.o_done, 0);
            if (beat == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", bus.o_valid, 0);
                chk("rst_busy", bus.o_busy, 0);
                chk("rst_coeff", bus.o_coeff, 0);
                chk("rst_last", bus.o_last, 0);
                repeat (2) @(posedge clk);
                #1;
                chk("rst_done", bus.o_done, 0);
                rst_n = 1'b1;
                bus.i_ready = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("post_rst_valid", bus.o_valid, 0);
                    chk("post_rst_done", bus.o_done, 0);
                end
                return;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_ready = rdy;
            bus.i_start = (beat == restart_at);
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            if (rdy) beat++;
            cyc++;
        end
        chk("timeout", cyc < MAX_CYC, 1);
        bus.i_ready = 1'b1;
        chk("done_pulse", bus.o_done, 1);
        chk("done_valid", bus.o_valid, 0);
        chk("done_last", bus.o_last, 0);
        chk("done_busy", bus.o_busy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_once", bus.o_done, 0);
            chk("idle_valid", bus.o_valid, 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_sum_one  = '0;
        bus.i_sum_mone = '0;

        // Reset state; start pulsed while in reset must not launch a stream
        #2;
        bus.i_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_coeff", bus.o_coeff, 0);
        chk("reset_valid", bus.o_valid, 0);
        chk("reset_last", bus.o_last, 0);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_done", bus.o_done, 0);
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_valid", bus.o_valid, 0);

        // Ramp: sum_one[k] = k mod 251, full throughput
        for (int k = 0; k < N; k++) begin
            so[k] = k % QI;
            sm[k] = 0;
        end
        run_poly(1'b0, -1, -1);

        // Wrap cases
        for (int k = 0; k < N; k++) begin so[k] = 0;   sm[k] = 1;   end
        run_poly(1'b0, -1, -1);
        for (int k = 0; k < N; k++) begin so[k] = 250; sm[k] = 250; end
        run_poly(1'b0, -1, -1);
        for (int k = 0; k < N; k++) begin so[k] = 5;   sm[k] = 250; end
        run_poly(1'b0, -1, -1);

        // Random data with random backpressure
        repeat (2) begin
            for (int k = 0; k < N; k++) begin
                so[k] = int'($urandom_range(0, QI - 1));
                sm[k] = int'($urandom_range(0, QI - 1));
            end
            run_poly(1'b1, -1, -1);
        end

        // Start re-pulsed mid-stream is ignored
        for (int k = 0; k < N; k++) begin
            so[k] = int'($urandom_range(0, QI - 1));
            sm[k] = int'($urandom_range(0, QI - 1));
        end
        run_poly(1'b1, 40, -1);

        // Reset mid-stream aborts, then a fresh start begins at beat 0
        run_poly(1'b0, -1, 60);
        for (int k = 0; k < N; k++) begin
            so[k] = int'($urandom_range(0, QI - 1));
            sm[k] = int'($urandom_range(0, QI - 1));
        end
        run_poly(1'b1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
